// File: rtl/disparity_sched.sv
// disparity_sched: bank-sequenced running-minimum disparity scheduler (optional watchdog: DISP_SCHED_TIMEOUT_EN)
module disparity_sched #(
  parameter int NCAND  = 64,
  parameter int NUNITS = 16,
  parameter int WIN    = 16,
  parameter int SW     = 18,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [6:0]           pix_x,
  input  logic [3:0]           pix_y,
  output logic                 startsig,
  output logic                 work,
  output logic [NUNITS-1:0]    change,
  output logic [DW-1:0]        base_disp,
  input  logic                 res_valid,
  input  logic [NUNITS*SW-1:0] res_score,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [DW-1:0]        d,
  output logic [SW-1:0]        d_score,
  output logic [6:0]           d_x,
  output logic [3:0]           d_y,
  output logic                 err
);
  localparam int NB = NCAND / NUNITS;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int KW = NUNITS > 1 ? $clog2(NUNITS) : 1;
  localparam int FW = WIN > 1 ? $clog2(WIN) : 1;

  if (NCAND > (1 << DW) || NCAND % NUNITS != 0) begin : g_bad_params
    $error("disparity_sched: NCAND must be a multiple of NUNITS and fit in DW bits");
  end

  typedef enum logic [2:0] {IDLE, START, FEED, WAIT, SCAN, DONE} state_t;
  state_t state, nxt;

  logic [BW-1:0]        bank;
  logic [KW-1:0]        scan_cnt;
  logic [FW-1:0]        feed_cnt;
  logic [NUNITS*SW-1:0] hold;
  logic [SW-1:0]        cur;
  logic                 best_ok, last_scan, last_bank, timeout;

  assign cur       = hold[32'(scan_cnt) * SW +: SW];
  assign last_scan = scan_cnt == KW'(NUNITS - 1);
  assign last_bank = bank == BW'(NB - 1);
  assign pix_ready = state == IDLE;
  assign startsig  = state == START;
  assign work      = state == FEED;
  assign change    = state == FEED ? NUNITS'(1) << (32'(feed_cnt) % NUNITS) : '0;
  assign base_disp = DW'(32'(bank) * NUNITS);
  assign d_valid   = state == DONE;

`ifdef DISP_SCHED_TIMEOUT_EN
  logic [7:0] tcnt;
  // watchdog restarted on every entry into WAIT
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= state == WAIT ? tcnt + 8'd1 : '0;
  assign timeout = state == WAIT && !res_valid && tcnt == 8'd255;
  // abort flag belongs to the pixel currently being reported
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (state == IDLE && pix_valid) err <= 1'b0;
    else if (timeout) err <= 1'b1;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  // pass sequencing: start, feed window, wait scores, scan bank, next bank or done
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = pix_valid ? START : IDLE;
      START:   nxt = FEED;
      FEED:    nxt = feed_cnt == FW'(WIN - 1) ? WAIT : FEED;
      WAIT:    nxt = res_valid ? SCAN : timeout ? DONE : WAIT;
      SCAN:    nxt = !last_scan ? SCAN : last_bank ? DONE : START;
      DONE:    nxt = d_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end

  // counters, score holding register and running minimum
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bank     <= '0;
      scan_cnt <= '0;
      feed_cnt <= '0;
      hold     <= '0;
      best_ok  <= 1'b0;
      d        <= '0;
      d_score  <= '0;
      d_x      <= '0;
      d_y      <= '0;
    end else begin
      feed_cnt <= state == FEED ? feed_cnt + 1'b1 : '0;
      scan_cnt <= state == SCAN ? scan_cnt + 1'b1 : '0;
      if (state == WAIT && res_valid) hold <= res_score;
      if (state == IDLE && pix_valid) begin
        d_x     <= pix_x;
        d_y     <= pix_y;
        bank    <= '0;
        best_ok <= 1'b0;
      end
      if (state == SCAN && last_scan && !last_bank) bank <= bank + 1'b1;
      if (state == SCAN && (!best_ok || cur < d_score)) begin
        best_ok <= 1'b1;
        d       <= base_disp + DW'(scan_cnt);
        d_score <= cur;
      end
      if (timeout) begin
        d       <= '1;
        d_score <= '1;
      end
    end
endmodule

// File: tb/tb_disparity_sched.sv
// tb_disparity_sched: table, random and corner-sequence checks of disparity_sched
module tb_disparity_sched;
  localparam int NCAND = 64, NUNITS = 16, WIN = 16, SW = 18, DW = 8;
  localparam int NB = NCAND / NUNITS;

  logic clk = 1'b0, rst = 1'b1;
  logic pix_valid = 1'b0, pix_ready;
  logic [6:0] pix_x = '0;
  logic [3:0] pix_y = '0;
  logic startsig, work;
  logic [NUNITS-1:0] change;
  logic [DW-1:0] base_disp, d;
  logic res_valid = 1'b0;
  logic [NUNITS*SW-1:0] res_score = '0;
  logic d_valid, d_ready = 1'b0, err;
  logic [SW-1:0] d_score;
  logic [6:0] d_x;
  logic [3:0] d_y;

  int checks = 0, errors = 0;
  logic [SW-1:0] sc [NCAND];

  typedef struct {
    int pat; int p0; int p1; int dly; int hold;
    logic [6:0] x; logic [3:0] y; logic [DW-1:0] ed; logic [SW-1:0] es;
  } vec_t;
  vec_t tbl [8];

  disparity_sched #(.NCAND(NCAND), .NUNITS(NUNITS), .WIN(WIN), .SW(SW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .startsig(startsig), .work(work), .change(change), .base_disp(base_disp),
    .res_valid(res_valid), .res_score(res_score), .d_valid(d_valid), .d_ready(d_ready),
    .d(d), .d_score(d_score), .d_x(d_x), .d_y(d_y), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic scramble();
    for (int k = 0; k < NUNITS; k++) res_score[k*SW +: SW] = SW'($urandom);
  endtask

  task automatic fill(input int pat, input int p0, input int p1);
    for (int i = 0; i < NCAND; i++)
      sc[i] = pat == 0 ? SW'(1000 + i) : pat == 1 ? SW'(500) : pat == 2 ? SW'(p0) : SW'(p0 - i);
    if (pat == 0) sc[p0] = SW'(p1);
    if (pat == 1) begin
      sc[p0] = SW'(7);
      sc[p1] = SW'(7);
    end
  endtask

  // reference: smallest score, earliest candidate among equals
  task automatic model(output logic [DW-1:0] ed, output logic [SW-1:0] es);
    logic [SW-1:0] mn;
    int best;
    mn = sc[0];
    for (int i = 1; i < NCAND; i++) if (sc[i] < mn) mn = sc[i];
    best = 0;
    for (int i = NCAND - 1; i >= 0; i--) if (sc[i] == mn) best = i;
    ed = DW'(best);
    es = mn;
  endtask

  task automatic run_pixel(input logic [6:0] x, input logic [3:0] y, input int dly,
                           input int stop_bank, input bit stop_in_wait, input bit stray);
    int cyc;
    pix_x = x;
    pix_y = y;
    pix_valid = 1'b1;
    chk("pix_ready_idle", pix_ready, 1);
    step();
    pix_valid = 1'b0;
    cyc = 1;
    chk("pix_ready_busy", pix_ready, 0);
    for (int b = 0; b < NB; b++) begin
      chk("startsig", startsig, 1);
      chk("start_work", work, 0);
      chk("base_disp", base_disp, b * NUNITS);
      step();
      cyc++;
      for (int w = 0; w < WIN; w++) begin
        if (b == stop_bank && !stop_in_wait && w == 5) return;
        chk("work", work, 1);
        chk("startsig_feed", startsig, 0);
        chk("change", change, 1 << (w % NUNITS));
        res_valid = stray && w == 3;
        step();
        cyc++;
        res_valid = 1'b0;
      end
      chk("wait_quiet", {work, startsig, change}, 0);
      if (b == stop_bank) return;
      repeat (dly) begin
        step();
        cyc++;
      end
      for (int k = 0; k < NUNITS; k++) res_score[k*SW +: SW] = sc[b*NUNITS + k];
      res_valid = 1'b1;
      step();
      cyc++;
      res_valid = 1'b0;
      scramble();
      repeat (NUNITS) begin
        chk("scan_quiet", {work, startsig, d_valid}, 0);
        step();
        cyc++;
      end
    end
    for (int i = 0; i < 64 && !d_valid; i++) begin
      step();
      cyc++;
    end
    chk("latency", cyc, 137 + NB * dly);
  endtask

  task automatic finish_pixel(input logic [6:0] x, input logic [3:0] y,
                              input logic [DW-1:0] ed, input logic [SW-1:0] es, input int hold);
    chk("d_valid", d_valid, 1);
    chk("d", d, ed);
    chk("d_score", d_score, es);
    chk("d_x", d_x, x);
    chk("d_y", d_y, y);
    chk("err", err, 0);
    d_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      pix_valid = 1'b1;
      pix_x = ~x;
      pix_y = ~y;
      step();
      chk("bp_stable", {d_valid, d, d_score, d_x, d_y, pix_ready}, {1'b1, ed, es, x, y, 1'b0});
    end
    pix_valid = 1'b0;
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
    chk("after_xfer", {d_valid, pix_ready}, 2'b01);
    step();
    chk("idle_hold", {pix_ready, startsig}, 2'b10);
  endtask

  initial begin
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [6:0] rx;
    logic [3:0] ry;
    int n;
    tbl[0] = '{0, 37, 12, 2, 0, 7'd5, 4'd3, 8'd37, 18'd12};
    tbl[1] = '{1, 20, 52, 0, 10, 7'd9, 4'd1, 8'd20, 18'd7};
    tbl[2] = '{2, 300, 0, 0, 1, 7'd127, 4'd15, 8'd0, 18'd300};
    tbl[3] = '{3, 5000, 0, 1, 0, 7'd0, 4'd0, 8'd63, 18'd4937};
    tbl[4] = '{0, 63, 0, 0, 3, 7'd64, 4'd8, 8'd63, 18'd0};
    tbl[5] = '{0, 0, 999, 3, 0, 7'd1, 4'd2, 8'd0, 18'd999};
    tbl[6] = '{2, 262143, 0, 0, 0, 7'd33, 4'd7, 8'd0, 18'd262143};
    tbl[7] = '{1, 15, 16, 0, 2, 7'd100, 4'd12, 8'd15, 18'd7};
    scramble();
    repeat (2) step();
    chk("reset_ready", pix_ready, 1);
    chk("reset_out_a", {startsig, work, change, base_disp, d_valid, err}, 0);
    chk("reset_out_b", {d, d_score, d_x, d_y}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].pat, tbl[i].p0, tbl[i].p1);
      run_pixel(tbl[i].x, tbl[i].y, tbl[i].dly, -1, 1'b0, i[0]);
      finish_pixel(tbl[i].x, tbl[i].y, tbl[i].ed, tbl[i].es, tbl[i].hold);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NCAND; i++)
        sc[i] = r[0] ? SW'($urandom_range(0, 40)) : SW'($urandom);
      model(ed, es);
      rx = 7'($urandom);
      ry = 4'($urandom);
      run_pixel(rx, ry, $urandom_range(0, 4), -1, 1'b0, 1'($urandom));
      finish_pixel(rx, ry, ed, es, $urandom_range(0, 3));
    end

    fill(0, 5, 3);
    run_pixel(7'd5, 4'd3, 0, 2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", pix_ready, 1);
    chk("midrst_out_a", {startsig, work, change, base_disp, d_valid, err}, 0);
    chk("midrst_out_b", {d, d_score, d_x, d_y}, 0);
    step();
    rst = 1'b0;
    n = 0;
    repeat (200) begin
      step();
      if (d_valid) n++;
    end
    chk("midrst_no_dvalid", n, 0);
    chk("midrst_idle", pix_ready, 1);

    fill(0, 40, 1);
    run_pixel(7'd11, 4'd6, 0, 1, 1'b1, 1'b0);
`ifdef DISP_SCHED_TIMEOUT_EN
    n = 0;
    while (!d_valid && n < 400) begin
      step();
      n++;
    end
    chk("timeout_window", n >= 255 && n <= 257, 1);
    chk("timeout_result", {d_valid, d, d_score, err}, {1'b1, 8'hFF, 18'h3FFFF, 1'b1});
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
    chk("timeout_xfer", {d_valid, pix_ready}, 2'b01);
`else
    repeat (1000) step();
    chk("still_wait", {d_valid, work, startsig, pix_ready, change, err}, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("wait_rst_idle", pix_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
